// File: rtl/xpb_table_gen.sv
// -----------------------------------------------------------------------------
// xpb_table_gen
//   Fills an xpb reduction lookup table at run time. For a base residue
//   B = 2^k mod M and a modulus M it streams entry[j] = j*B mod M,
//   j = 0 .. 2**IDX_BITS-1, out on a RAM write port by running modular
//   accumulation (acc += B, subtract M once if the sum reached M).
//
//   Timing for a start accepted at edge T:
//     T+1                       B/M sanity check (error pulse if rejected)
//     T+2 .. T+1+NUM_ENTRIES    one table write per cycle, address 0 upward
//     T+2+NUM_ENTRIES           done pulse, busy drops
//   The add/compare is single-cycle, so there is no extra pipeline latency.
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   start    generation request, only honoured in IDLE
//   base     B, captured on an accepted start
//   modulus  M, captured on an accepted start
//   busy     high from accepted start until the done/error pulse
//   done     one-cycle pulse after the last table write
//   error    one-cycle pulse when B >= M or M == 0
//   wr_en    table write strobe
//   wr_addr  table index j (held while wr_en is low)
//   wr_data  j*B mod M      (held while wr_en is low)
// -----------------------------------------------------------------------------
module xpb_table_gen #(
  parameter int WIDTH    = 1024,
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    base,
  input  logic [WIDTH-1:0]    modulus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                wr_en,
  output logic [IDX_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]    wr_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  localparam logic [IDX_BITS-1:0] LAST_IDX = {IDX_BITS{1'b1}};
  localparam logic [IDX_BITS-1:0] IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};

  // (a + b) mod m for a, b < m; the sum is one bit wider so it cannot overflow,
  // and a single conditional subtract is enough to land back below m.
  function automatic logic [WIDTH-1:0] mod_add(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, m}) begin
      mod_add = sum[WIDTH-1:0] - m;
    end else begin
      mod_add = sum[WIDTH-1:0];
    end
  endfunction

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    base_q, base_d;
  logic [WIDTH-1:0]    mod_q, mod_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                wr_en_q, wr_en_d;
  logic [IDX_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;

  logic                accept_s;
  logic                reject_s;
  logic [WIDTH-1:0]    acc_next_s;

  // A start coinciding with the done pulse is dropped: the next run may only
  // begin from the IDLE cycle after that pulse.
  assign accept_s   = (state_q == S_IDLE) && start && !done_q;
  assign reject_s   = (base_q >= mod_q) || (mod_q == {WIDTH{1'b0}});
  assign acc_next_s = mod_add(acc_q, base_q, mod_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (reject_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and datapath next values; pulses default low, everything else holds.
  always_comb begin
    base_d    = base_q;
    mod_d     = mod_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          base_d = base;
          mod_d  = modulus;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_CHECK: begin
        if (reject_s) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          acc_d = {WIDTH{1'b0}};
          idx_d = {IDX_BITS{1'b0}};
        end
      end
      S_RUN: begin
        wr_en_d   = 1'b1;
        wr_addr_d = idx_q;
        wr_data_d = acc_q;
        acc_d     = acc_next_s;
        idx_d     = idx_q + IDX_ONE;
      end
      S_FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= {WIDTH{1'b0}};
      mod_q     <= {WIDTH{1'b0}};
      acc_q     <= {WIDTH{1'b0}};
      idx_q     <= {IDX_BITS{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {IDX_BITS{1'b0}};
      wr_data_q <= {WIDTH{1'b0}};
    end else begin
      base_q    <= base_d;
      mod_q     <= mod_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
